fetch_stage: RTL and testbench

Instruction fetch stage that sits directly upstream of the control unit. It holds the program counter and issues word fetches to instruction memory over a request/grant/response handshake. It presents each fetched instruction, its PC, PC+4 and its 7-bit opcode field to decode through a valid/ready handshake. Branch and jump resolution redirects the PC via `redirect`, which squashes any in-flight or held instruction.

---
 rtl/fetch_stage.sv | 96 +++++++++
 tb/tb_fetch_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one outstanding word fetch at a time,
// and hands each instruction to decode through a valid/ready handshake.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [6:0]  id_opcode,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2,
      DROP = 2'd3
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic [31:0] id_pc_q;
   logic [31:0] target_d;
   logic [31:0] pc_plus4_d;

   assign target_d   = {redirect_pc[31:2], 2'b00};
   assign pc_plus4_d = pc_q + 32'd4;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= REQ;
         pc_q    <= RESET_PC;
         instr_q <= NOP;
         id_pc_q <= RESET_PC;
      end else begin
         unique case (state_q)
            REQ: begin
               if (redirect) begin
                  pc_q    <= target_d;
                  state_q <= imem_gnt ? DROP : REQ;
               end else if (imem_gnt) begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (redirect) begin
                  pc_q    <= target_d;
                  state_q <= imem_rvalid ? REQ : DROP;
               end else if (imem_rvalid) begin
                  instr_q <= imem_rdata;
                  id_pc_q <= pc_q;
                  pc_q    <= pc_plus4_d;
                  state_q <= HOLD;
               end
            end
            HOLD: begin
               if (redirect) begin
                  pc_q    <= target_d;
                  state_q <= REQ;
               end else if (id_ready) begin
                  state_q <= REQ;
               end
            end
            DROP: begin
               // The killed request's response still has to drain before a new request.
               if (redirect) pc_q <= target_d;
               if (imem_rvalid) state_q <= REQ;
            end
            default: state_q <= REQ;
         endcase
      end
   end

   // Request is gated by rst_n so nothing is issued while memory is held in reset.
   assign imem_req    = (state_q == REQ) && rst_n;
   assign imem_addr   = pc_q;
   assign id_valid    = (state_q == HOLD);
   assign id_instr    = instr_q;
   assign id_opcode   = instr_q[6:0];
   assign id_pc       = id_pc_q;
   assign id_pc_plus4 = id_pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: one task per scenario, inline comparisons against
// hand-computed values, summary of passed/total checks at the end.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [6:0]  id_opcode;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;

   fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
      .id_opcode(id_opcode), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
      redirect = 0; redirect_pc = 0; id_ready = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (id_valid !== 1'b0) $display("FAIL rst_id_valid got=%b exp=0", id_valid); else passed++;
         total++; if (id_instr !== 32'h13) $display("FAIL rst_id_instr got=%h exp=00000013", id_instr); else passed++;
         total++; if (imem_req !== 1'b0) $display("FAIL rst_imem_req got=%b exp=0", imem_req); else passed++;
      end
      total++; if (id_opcode !== 7'b0010011) $display("FAIL rst_opcode got=%b exp=0010011", id_opcode); else passed++;
      total++; if (id_pc !== 32'h100) $display("FAIL rst_id_pc got=%h exp=00000100", id_pc); else passed++;
      total++; if (id_pc_plus4 !== 32'h104) $display("FAIL rst_pc_plus4 got=%h exp=00000104", id_pc_plus4); else passed++;
      rst_n = 1'b1;
      step();
      total++; if (imem_req !== 1'b1) $display("FAIL post_rst_req got=%b exp=1", imem_req); else passed++;
      total++; if (imem_addr !== 32'h100) $display("FAIL post_rst_addr got=%h exp=00000100", imem_addr); else passed++;
   endtask

   task automatic test_straight_line();
      int v0, v1;
      id_ready = 1;
      imem_gnt = 1;
      step();
      imem_gnt = 0;
      total++; if (imem_req !== 1'b0) $display("FAIL sl_wait_req got=%b exp=0", imem_req); else passed++;
      total++; if (id_valid !== 1'b0) $display("FAIL sl_wait_valid got=%b exp=0", id_valid); else passed++;
      imem_rvalid = 1; imem_rdata = 32'h00500093;
      step();
      imem_rvalid = 0;
      v0 = cyc;
      total++; if (id_valid !== 1'b1) $display("FAIL sl_valid0 got=%b exp=1", id_valid); else passed++;
      total++; if (id_pc !== 32'h100) $display("FAIL sl_pc0 got=%h exp=00000100", id_pc); else passed++;
      total++; if (id_instr !== 32'h00500093) $display("FAIL sl_instr0 got=%h exp=00500093", id_instr); else passed++;
      total++; if (id_opcode !== 7'b0010011) $display("FAIL sl_op0 got=%b exp=0010011", id_opcode); else passed++;
      step();
      total++; if (id_valid !== 1'b0) $display("FAIL sl_valid0_fall got=%b exp=0", id_valid); else passed++;
      total++; if (imem_addr !== 32'h104 || imem_req !== 1'b1) $display("FAIL sl_req1 got=%b/%h exp=1/00000104", imem_req, imem_addr); else passed++;
      imem_gnt = 1;
      step();
      imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h00A00113;
      step();
      imem_rvalid = 0;
      v1 = cyc;
      total++; if (id_pc !== 32'h104 || id_valid !== 1'b1) $display("FAIL sl_pc1 got=%h/%b exp=00000104/1", id_pc, id_valid); else passed++;
      total++; if (id_opcode !== 7'b0010011) $display("FAIL sl_op1 got=%b exp=0010011", id_opcode); else passed++;
      total++; if (v1 - v0 !== 3) $display("FAIL sl_spacing got=%0d exp=3", v1 - v0); else passed++;
      total++; if (id_pc_plus4 !== 32'h108) $display("FAIL sl_plus4 got=%h exp=00000108", id_pc_plus4); else passed++;
      step();
      total++; if (imem_addr !== 32'h108 || imem_req !== 1'b1) $display("FAIL sl_req2 got=%b/%h exp=1/00000108", imem_req, imem_addr); else passed++;
   endtask

   task automatic test_stall();
      id_ready = 0;
      imem_gnt = 1;
      step();
      imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h00000517;
      step();
      imem_rvalid = 0; imem_rdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 5; i++) begin
         step();
         total++; if (id_valid !== 1'b1 || id_instr !== 32'h00000517 || id_pc !== 32'h108)
            $display("FAIL stall_hold got=%b/%h/%h exp=1/00000517/00000108", id_valid, id_instr, id_pc); else passed++;
         total++; if (imem_req !== 1'b0) $display("FAIL stall_req got=%b exp=0", imem_req); else passed++;
      end
      total++; if (id_opcode !== 7'h17) $display("FAIL stall_op got=%h exp=17", id_opcode); else passed++;
      id_ready = 1;
      step();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h10C) $display("FAIL stall_next got=%b/%h exp=1/0000010c", imem_req, imem_addr); else passed++;
   endtask

   task automatic test_redirect_inflight();
      imem_gnt = 1; redirect = 1; redirect_pc = 32'h203;
      step();
      imem_gnt = 0; redirect = 0;
      total++; if (imem_req !== 1'b0) $display("FAIL rif_drop_req got=%b exp=0", imem_req); else passed++;
      step();
      total++; if (imem_req !== 1'b0 || id_valid !== 1'b0) $display("FAIL rif_drop_wait got=%b/%b exp=0/0", imem_req, id_valid); else passed++;
      imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
      step();
      imem_rvalid = 0;
      total++; if (id_valid !== 1'b0) $display("FAIL rif_no_valid got=%b exp=0", id_valid); else passed++;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) $display("FAIL rif_target got=%b/%h exp=1/00000200", imem_req, imem_addr); else passed++;
      step();
      total++; if (id_valid !== 1'b0 || id_instr !== 32'h00000517) $display("FAIL rif_squash got=%b/%h exp=0/00000517", id_valid, id_instr); else passed++;
   endtask

   task automatic test_redirect_vs_ready();
      imem_gnt = 1;
      step();
      imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h00000063;
      step();
      imem_rvalid = 0;
      total++; if (id_valid !== 1'b1 || id_pc !== 32'h200) $display("FAIL rvr_hold got=%b/%h exp=1/00000200", id_valid, id_pc); else passed++;
      redirect = 1; redirect_pc = 32'h40; id_ready = 1;
      step();
      redirect = 0;
      total++; if (id_valid !== 1'b0) $display("FAIL rvr_valid got=%b exp=0", id_valid); else passed++;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) $display("FAIL rvr_target got=%b/%h exp=1/00000040", imem_req, imem_addr); else passed++;
   endtask

   task automatic test_redirect_wait_and_req();
      imem_gnt = 1;
      step();
      imem_gnt = 0; redirect = 1; redirect_pc = 32'h80;
      step();
      redirect = 0;
      total++; if (imem_req !== 1'b0) $display("FAIL rw_drop got=%b exp=0", imem_req); else passed++;
      imem_rvalid = 1; imem_rdata = 32'h1111_1111;
      step();
      imem_rvalid = 0;
      total++; if (id_valid !== 1'b0 || imem_addr !== 32'h80 || imem_req !== 1'b1)
         $display("FAIL rw_target got=%b/%b/%h exp=0/1/00000080", id_valid, imem_req, imem_addr); else passed++;
      redirect = 1; redirect_pc = 32'h93;
      step();
      redirect = 0;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h90) $display("FAIL rq_target got=%b/%h exp=1/00000090", imem_req, imem_addr); else passed++;
   endtask

   task automatic test_wrap();
      redirect = 1; redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect = 0;
      total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr); else passed++;
      imem_gnt = 1;
      step();
      imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h00000013;
      step();
      imem_rvalid = 0;
      total++; if (id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0) $display("FAIL wrap_plus4 got=%h/%h exp=fffffffc/00000000", id_pc, id_pc_plus4); else passed++;
      step();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL wrap_next got=%b/%h exp=1/00000000", imem_req, imem_addr); else passed++;
   endtask

   task automatic test_reset_mid();
      imem_gnt = 1;
      step();
      imem_gnt = 0;
      rst_n = 0;
      step();
      total++; if (imem_req !== 1'b0 || id_valid !== 1'b0) $display("FAIL mrst_ctl got=%b/%b exp=0/0", imem_req, id_valid); else passed++;
      total++; if (id_instr !== 32'h13 || id_pc !== 32'h100) $display("FAIL mrst_data got=%h/%h exp=00000013/00000100", id_instr, id_pc); else passed++;
      rst_n = 1;
      step();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) $display("FAIL mrst_req got=%b/%h exp=1/00000100", imem_req, imem_addr); else passed++;
   endtask

   initial begin
      test_reset();
      test_straight_line();
      test_stall();
      test_redirect_inflight();
      test_redirect_vs_ready();
      test_redirect_wait_and_req();
      test_wrap();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
